fetch_redirect: RTL and testbench
=================================

Name: fetch_redirect

Overview:
- Consumer side of the pipeline flush protocol.
- Takes the per-cycle flush request (none / branch-class / writeback-class) and the redirect targets, and owns the fetch PC.
- Drives the instruction-bus request handshake and discards any in-flight response made stale by a redirect.
- Presents one fetched instruction at a time to decode, with a decode-side stall.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- XLEN, 64, PC/address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  2  flush request: 2'd0 none, 2'd1 branch-class (target br_pc_i), 2'd2 writeback-class (target wb_pc_i), 2'd3 treated as 2'd2.
- br_pc_i  in  XLEN  branch/jump target.
- wb_pc_i  in  XLEN  trap/CSR/MRET target.
- ireq_valid_o  out  1  fetch request valid.
- ireq_addr_o  out  XLEN  fetch address.
- iresp_addr_ok_i  in  1  request accepted this cycle.
- iresp_data_ok_i  in  1  response data valid this cycle.
- iresp_data_i  in  32  instruction word.
- stall_i  in  1  decode cannot accept.
- inst_valid_o  out  1  instruction to decode valid.
- inst_o  out  32  instruction.
- inst_pc_o  out  XLEN  PC of inst_o.

Behaviour:
- Reset values:
  - pc=RESET_PC, state=REQ.
  - ireq_valid_o=0 during reset, 1 in the first cycle after release.
  - inst_valid_o=0; inst_o=0; inst_pc_o=0.
  - pending-redirect flag=0.
- States:
  - REQ: ireq_valid_o=1, ireq_addr_o=pc.
    - addr_ok → WAIT; the issued PC is latched into req_pc.
  - WAIT: ireq_valid_o=0.
    - data_ok with output slot free → load slot (inst, req_pc); pc=req_pc+4; → REQ.
    - data_ok with slot occupied cannot occur: the slot is freed before data returns, see "Output slot".
  - DISCARD: ireq_valid_o=0.
    - data_ok → drop data; pc=latched redirect target; → REQ.
- Output slot:
  - One entry.
  - inst_valid_o stays high while stall_i=1.
  - The slot clears when stall_i=0 at a clock edge.
  - A new request is issued only when the slot is empty, or when it clears in the same cycle; otherwise the FSM waits in REQ with ireq_valid_o=0.
  - One instruction in flight maximum.
- Flush handling:
  - flush_i takes effect at the clock edge it is sampled.
  - Target = wb_pc_i if flush_i[1], else br_pc_i (writeback-class wins).
  - The output slot is cleared unconditionally; inst_valid_o=0 the next cycle, regardless of stall_i.
  - In REQ without addr_ok: pc=target, stay REQ. The new address is driven next cycle; the request is not withdrawn mid-handshake.
  - In REQ with addr_ok in the same cycle: stale request accepted → DISCARD with the target latched.
  - In WAIT without data_ok: → DISCARD, target latched.
  - In WAIT with data_ok in the same cycle: data dropped; pc=target; → REQ.
  - In DISCARD: the latched target is overwritten by the newer flush; stays DISCARD.
- Reset asserted mid-transaction: immediate return to reset values. A response arriving after release is not expected; the bus is reset by the same signal.
- PC arithmetic: +4 modulo 2^XLEN; wrap-around is not flagged.
- Latency:
  - Back-to-back fetches: REQ→WAIT→REQ, min 2 cycles per instruction.
  - After a flush, the first request to the target appears the next cycle (REQ/WAIT+data_ok) or one cycle after the stale data_ok (DISCARD).

Optional Feature:
- FETCH_PERF_CNT_EN: adds outputs perf_redirects_o and perf_discards_o (both 32-bit).
  - perf_redirects_o counts edges where flush_i≠0.
  - perf_discards_o counts dropped responses: DISCARD data_ok, or WAIT data_ok coincident with a flush.
  - Both counters are reset to 0 and saturate at 32'hFFFF_FFFF.
- Without the macro: no counter ports, no counter logic.

Test Plan:
- Reset release, addr_ok=1 every REQ, data_ok one cycle after accept, stall_i=0 → addresses 0x80000000, 0x80000004, 0x80000008; inst_pc_o follows, one instruction every 2 cycles.
- stall_i=1 for 3 cycles with slot full → inst_o/inst_pc_o stable, ireq_valid_o=0; released → next request 0x...+4 the following cycle.
- Redirect during WAIT: flush_i=1, br_pc_i=0x80001000 → state DISCARD; the returning 0xDEADBEEF is never on inst_o; next request addr 0x80001000.
- flush_i=1 with br_pc_i=0x80000100 in the same cycle as flush_i=2 with wb_pc_i=0x80000200 → next request addr 0x80000200.
- Flush coincident with addr_ok in REQ → DISCARD. A second flush (wb_pc_i=0x80000300) while in DISCARD → after data_ok, request addr 0x80000300.
- reset asserted while in WAIT → outputs return to reset values asynchronously; after release, first request 0x80000000. With FETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/fetch_redirect.sv
// fetch_redirect: owns the fetch PC, issues one instruction-bus request at a
// time, drops responses made stale by a redirect, and holds one fetched
// instruction for decode.
// Optional build macro FETCH_PERF_CNT_EN adds saturating redirect/discard counters.
module fetch_redirect #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      flush_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] wb_pc_i,
  output logic            ireq_valid_o,
  output logic [XLEN-1:0] ireq_addr_o,
  input  logic            iresp_addr_ok_i,
  input  logic            iresp_data_ok_i,
  input  logic [31:0]     iresp_data_i,
  input  logic            stall_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_redirects_o,
  output logic [31:0]     perf_discards_o
`endif
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DISCARD
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] redir_pc;

  logic            flush;
  logic [XLEN-1:0] flush_tgt;
  logic            slot_free;
  logic            req_fire;

  // Flush decode, slot availability and the request handshake.
  // The reset gate only shapes the port; flops see the ungated fire term.
  always_comb begin
    flush        = |flush_i;
    flush_tgt    = flush_i[1] ? wb_pc_i : br_pc_i;
    slot_free    = !inst_valid_o || !stall_i;
    req_fire     = (state == S_REQ) && slot_free && iresp_addr_ok_i;
    ireq_valid_o = reset && (state == S_REQ) && slot_free;
    ireq_addr_o  = pc;
  end

  // Fetch FSM: PC ownership, request tracking and stale-response discard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      req_pc   <= '0;
      redir_pc <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            req_pc <= pc;
            if (flush) begin
              redir_pc <= flush_tgt;
              state    <= S_DISCARD;
            end else begin
              state    <= S_WAIT;
            end
          end else if (flush) begin
            pc <= flush_tgt;
          end
        end
        S_WAIT: begin
          if (iresp_data_ok_i) begin
            state <= S_REQ;
            pc    <= flush ? flush_tgt : req_pc + PC_STEP;
          end else if (flush) begin
            redir_pc <= flush_tgt;
            state    <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (iresp_data_ok_i) begin
            state <= S_REQ;
            pc    <= flush ? flush_tgt : redir_pc;
          end else if (flush) begin
            redir_pc <= flush_tgt;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // Single-entry output slot toward decode; a flush always empties it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
    end else if (flush) begin
      inst_valid_o <= 1'b0;
    end else if ((state == S_WAIT) && iresp_data_ok_i) begin
      inst_valid_o <= 1'b1;
      inst_o       <= iresp_data_i;
      inst_pc_o    <= req_pc;
    end else if (!stall_i) begin
      inst_valid_o <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic dropped;

  // A response is dropped when it lands in DISCARD or races a flush in WAIT.
  always_comb begin
    dropped = iresp_data_ok_i &&
              ((state == S_DISCARD) || ((state == S_WAIT) && flush));
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_redirects_o <= '0;
      perf_discards_o  <= '0;
    end else begin
      if (flush && (perf_redirects_o != '1))
        perf_redirects_o <= perf_redirects_o + 32'd1;
      if (dropped && (perf_discards_o != '1))
        perf_discards_o <= perf_discards_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// tb_fetch_redirect: directed scenarios plus randomized traffic. The reference
// model is an instruction-stream view: decode must see consecutive PCs from
// the last redirect target, each carrying the memory word at that PC.
module tb_fetch_redirect;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  flush_i = '0;
  logic [63:0] br_pc_i = '0;
  logic [63:0] wb_pc_i = '0;
  logic        ireq_valid_o;
  logic [63:0] ireq_addr_o;
  logic        iresp_addr_ok_i = 1'b0;
  logic        iresp_data_ok_i = 1'b0;
  logic [31:0] iresp_data_i = '0;
  logic        stall_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_o;
  logic [31:0] perf_discards_o;
`endif

  fetch_redirect #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .br_pc_i         (br_pc_i),
    .wb_pc_i         (wb_pc_i),
    .ireq_valid_o    (ireq_valid_o),
    .ireq_addr_o     (ireq_addr_o),
    .iresp_addr_ok_i (iresp_addr_ok_i),
    .iresp_data_ok_i (iresp_data_ok_i),
    .iresp_data_i    (iresp_data_i),
    .stall_i         (stall_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects_o(perf_redirects_o),
    .perf_discards_o (perf_discards_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_pops = 0;
  int          n_redir = 0;
  bit          saw_bad = 1'b0;
  logic [63:0] exp_q[$];

  // Bus responder knobs and state.
  int unsigned p_ok = 100;
  int unsigned dmin = 0;
  int unsigned dmax = 0;
  bit          outstanding = 1'b0;
  logic [63:0] out_addr = '0;
  int unsigned delay = 0;
  bit          force_en = 1'b0;
  logic [31:0] force_d = '0;
  logic [63:0] acc_log[$];
  int unsigned acc_cyc[$];

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting, required event never seen", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard update on a redirect: stream restarts at the winning target.
  task automatic apply_flush(input logic [1:0] f, input logic [63:0] br, input logic [63:0] wb);
    flush_i = f;
    br_pc_i = br;
    wb_pc_i = wb;
    exp_q.delete();
    exp_q.push_back(f[1] ? wb : br);
    n_redir++;
    tick();
    flush_i = 2'd0;
  endtask

  task automatic wait_acc(input int unsigned n0, input string name, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < 60; i++) begin
      if (acc_log.size() > n0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_timeout(name);
  endtask

  task automatic wait_outstanding(input bit level, input string name);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < 60; i++) begin
      if (outstanding == level) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_timeout(name);
  endtask

  // Instruction bus model: one outstanding request, response after a delay.
  initial begin
    bit          acc;
    bit          dat;
    logic [63:0] acc_a;
    forever begin
      @(negedge clk);
      acc   = reset && ireq_valid_o && iresp_addr_ok_i;
      acc_a = ireq_addr_o;
      dat   = reset && iresp_data_ok_i;
      @(posedge clk);
      #1;
      if (!reset) begin
        outstanding     = 1'b0;
        iresp_data_ok_i = 1'b0;
        iresp_addr_ok_i = 1'b0;
        force_en        = 1'b0;
        continue;
      end
      if (dat) begin
        outstanding = 1'b0;
        force_en    = 1'b0;
      end
      if (acc) begin
        outstanding = 1'b1;
        out_addr    = acc_a;
        delay       = $urandom_range(dmax, dmin);
        acc_log.push_back(acc_a);
        acc_cyc.push_back(cyc_n);
      end
      iresp_data_ok_i = 1'b0;
      iresp_data_i    = '0;
      if (outstanding) begin
        if (delay == 0) begin
          iresp_data_ok_i = 1'b1;
          iresp_data_i    = force_en ? force_d : mem(out_addr);
        end else begin
          delay--;
        end
      end
      iresp_addr_ok_i = ($urandom_range(99) < p_ok);
    end
  end

  // Monitor: every instruction decode takes must match the expected stream.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset && inst_valid_o && inst_o == 32'hDEAD_BEEF) saw_bad = 1'b1;
      if (reset && inst_valid_o && !stall_i && flush_i == 2'd0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got pc %h, required no instruction", inst_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", inst_pc_o, e);
          check("sb_inst", {32'h0, inst_o}, {32'h0, mem(e)});
          exp_q.push_back(e + 64'd4);
          n_pops++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int unsigned n0;
    logic [63:0] s_pc;
    logic [31:0] s_inst;
    logic [1:0]  f;
    logic [63:0] tgt;

    exp_q.push_back(RST_PC);
    #1 reset = 1'b0;
    #2;
    check("rst_ireq_valid", {63'h0, ireq_valid_o}, 64'd0);
    check("rst_inst_valid", {63'h0, inst_valid_o}, 64'd0);
    check("rst_inst", {32'h0, inst_o}, 64'd0);
    check("rst_inst_pc", inst_pc_o, 64'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rel_ireq_valid", {63'h0, ireq_valid_o}, 64'd1);
    check("rel_ireq_addr", ireq_addr_o, RST_PC);

    // Back-to-back fetch: addresses step by 4, one accept every 2 cycles.
    ok = 1'b0;
    for (int unsigned i = 0; i < 30; i++) begin
      if (acc_log.size() >= 3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_timeout("b2b_accepts");
    else begin
      check("b2b_addr0", acc_log[0], 64'h8000_0000);
      check("b2b_addr1", acc_log[1], 64'h8000_0004);
      check("b2b_addr2", acc_log[2], 64'h8000_0008);
      check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
      check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd2);
    end

    // Decode stall with a full slot.
    ok = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (inst_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_timeout("stall_slot_full");
    stall_i = 1'b1;
    #1;
    s_pc   = inst_pc_o;
    s_inst = inst_o;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("stall_inst", {32'h0, inst_o}, {32'h0, s_inst});
      check("stall_pc", inst_pc_o, s_pc);
      check("stall_no_req", {63'h0, ireq_valid_o}, 64'd0);
    end
    stall_i = 1'b0;
    #1;
    check("unstall_req", {63'h0, ireq_valid_o}, 64'd1);
    check("unstall_addr", ireq_addr_o, s_pc + 64'd4);

    // Redirect while waiting; the stale 0xDEADBEEF response must vanish.
    dmin = 3;
    dmax = 3;
    wait_outstanding(1'b0, "wait_idle_t3");
    wait_outstanding(1'b1, "wait_busy_t3");
    force_d  = 32'hDEAD_BEEF;
    force_en = 1'b1;
    saw_bad  = 1'b0;
    apply_flush(2'd1, 64'h8000_1000, 64'h0);
    check("discard_no_req", {63'h0, ireq_valid_o}, 64'd0);
    n0 = acc_log.size();
    wait_acc(n0, "redir_wait_acc", ok);
    if (ok) check("redir_addr", acc_log[n0], 64'h8000_1000);

    // Both classes at once: writeback target wins.
    dmin = 0;
    dmax = 1;
    apply_flush(2'd3, 64'h8000_0100, 64'h8000_0200);
    n0 = acc_log.size();
    wait_acc(n0, "prio_wait_acc", ok);
    if (ok) check("prio_addr", acc_log[n0], 64'h8000_0200);
    repeat (8) tick();
    check("no_stale_deadbeef", {63'h0, saw_bad}, 64'd0);

    // Flush coincident with accept, then a newer flush while discarding.
    dmin = 3;
    dmax = 3;
    ok = 1'b0;
    for (int unsigned i = 0; i < 30; i++) begin
      if (ireq_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_timeout("t5_req_valid");
    n0 = acc_log.size();
    apply_flush(2'd1, 64'h8000_0500, 64'h0);
    check("t5_stale_accepted", 64'(acc_log.size()), 64'(n0 + 1));
    check("t5_discard_no_req", {63'h0, ireq_valid_o}, 64'd0);
    apply_flush(2'd2, 64'h0, 64'h8000_0300);
    n0 = acc_log.size();
    wait_acc(n0, "t5_wait_acc", ok);
    if (ok) check("t5_addr", acc_log[n0], 64'h8000_0300);

    // Asynchronous reset while waiting.
    wait_outstanding(1'b0, "wait_idle_t6");
    wait_outstanding(1'b1, "wait_busy_t6");
    #3 reset = 1'b0;
    #1;
    check("mid_rst_ireq_valid", {63'h0, ireq_valid_o}, 64'd0);
    check("mid_rst_inst_valid", {63'h0, inst_valid_o}, 64'd0);
    check("mid_rst_inst", {32'h0, inst_o}, 64'd0);
    check("mid_rst_inst_pc", inst_pc_o, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("mid_rst_perf_redir", {32'h0, perf_redirects_o}, 64'd0);
    check("mid_rst_perf_disc", {32'h0, perf_discards_o}, 64'd0);
`endif
    repeat (2) tick();
    exp_q.delete();
    exp_q.push_back(RST_PC);
    n_redir = 0;
    reset = 1'b1;
    n0 = acc_log.size();
    wait_acc(n0, "rerst_wait_acc", ok);
    if (ok) check("rerst_addr", acc_log[n0], RST_PC);

    // Randomized traffic: stalls, redirects (including the wrap region), bus jitter.
    p_ok = 70;
    dmin = 0;
    dmax = 3;
    for (int unsigned i = 0; i < 3000; i++) begin
      stall_i = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 6) begin
        f = 2'($urandom_range(3, 1));
        if ($urandom_range(7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
        else tgt = 64'h8000_0000 + 64'($urandom_range(255) * 4);
        if (f[1]) apply_flush(f, 64'h8000_0000 + 64'($urandom_range(255) * 4), tgt);
        else apply_flush(f, tgt, 64'h8000_0000 + 64'($urandom_range(255) * 4));
      end else begin
        tick();
      end
    end
    stall_i = 1'b0;
    repeat (10) tick();
    check("rand_progress", {63'h0, (n_pops >= 100)}, 64'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_redirects", {32'h0, perf_redirects_o}, 64'(n_redir));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
